// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//   Host-to-device PS/2 transmitter. Inhibits the bus, issues request-to-send,
//   shifts one command byte (LSB first, odd parity, stop) out on device clock
//   falling edges and samples the device acknowledge bit. A watchdog aborts the
//   transfer if the device stops clocking.
//
// Ports
//   clk          system clock, rising edge
//   clrn         asynchronous active-low reset
//   tx_data      command byte, sampled on handshake
//   tx_valid     request to send tx_data
//   tx_ready     high only while idle; handshake = tx_valid & tx_ready
//   ps2_clk_i    PS/2 clock pin level (asynchronous)
//   ps2_data_i   PS/2 data pin level (asynchronous)
//   ps2_clk_oe   1 = pull ps2_clk low
//   ps2_data_oe  1 = pull ps2_data low
//   busy         ~tx_ready; receive path ignores the bus while high
//   done         one-cycle pulse at end of transfer
//   ack_ok       with done: device acknowledged
//   timeout      with done: watchdog expired
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       timeout
);

  // state     | meaning
  // IDLE      | lines released, ready for a command
  // INHIBIT   | ps2_clk held low for INHIBIT_CYCLES
  // REQ       | clk released, data low (start bit), waiting for edge 1
  // XFER      | edges 1..10 shift data, parity and stop
  // ACK       | waiting for edge 11, sample acknowledge
  // WAIT_IDLE | waiting for both lines high
  // DONE      | one-cycle completion pulse

  localparam int unsigned MAXC = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES
                                                                     : INHIBIT_CYCLES;
  localparam int CW = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] INH_LOAD = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] WD_LOAD  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_XFER, S_ACK, S_WAIT_IDLE, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    clk_sync_q;
  logic [1:0]    data_sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8:0]    shift_q, shift_d;
  logic [3:0]    edge_q, edge_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          ack_q, ack_d;
  logic          to_q, to_d;
  logic          fall, clk_s, data_s, hs, wd_active;

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];
  assign fall   = clk_sync_q[2] & ~clk_sync_q[1];
  assign hs     = tx_valid & ready_q;

  // Synchronizers reset to the idle-high bus level so no edge appears at reset.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      edge_q    <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      ack_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      edge_q    <= edge_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      ack_q     <= ack_d;
      to_q      <= to_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    edge_d    = edge_q;
    data_oe_d = data_oe_q;
    ack_d     = ack_q;
    to_d      = to_q;
    wd_active = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hs) begin
          state_d = S_INHIBIT;
          cnt_d   = INH_LOAD;
          shift_d = {~^tx_data, tx_data};
          edge_d  = '0;
          ack_d   = 1'b0;
          to_d    = 1'b0;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == '0) begin
          state_d   = S_REQ;
          cnt_d     = WD_LOAD;
          data_oe_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_REQ: begin
        wd_active = 1'b1;
        if (fall) begin
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b1, shift_q[8:1]};
          edge_d    = 4'd1;
          state_d   = S_XFER;
        end
      end
      S_XFER: begin
        wd_active = 1'b1;
        if (fall) begin
          // Ones shifted in behind parity become the stop bit on edge 10.
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b1, shift_q[8:1]};
          edge_d    = edge_q + 4'd1;
          if (edge_q == 4'd9) state_d = S_ACK;
        end
      end
      S_ACK: begin
        wd_active = 1'b1;
        if (fall) begin
          ack_d   = ~data_s;
          state_d = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        wd_active = 1'b1;
        if (clk_s && data_s) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Watchdog shares the counter; a falling edge beats expiry in the same cycle.
    if (wd_active) begin
      if (fall) begin
        cnt_d = WD_LOAD;
      end else if (cnt_q == '0) begin
        state_d = S_DONE;
        to_d    = 1'b1;
        ack_d   = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    if (state_d inside {S_IDLE, S_INHIBIT, S_WAIT_IDLE, S_DONE}) data_oe_d = 1'b0;
    clk_oe_d = (state_d == S_INHIBIT);
    ready_d  = (state_d == S_IDLE);
    done_d   = (state_d == S_DONE);
  end

  assign tx_ready    = ready_q;
  assign busy        = ~ready_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign done        = done_q;
  assign ack_ok      = ack_q;
  assign timeout     = to_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;
  localparam int INH = 8;
  localparam int TMO = 200;
  localparam int H   = 15;  // device clock half-period in system cycles

  logic       clk = 1'b0;
  logic       clrn;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, busy, done, ack_ok, timeout;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk, dev_data;
  logic       ps2_clk_pin, ps2_data_pin;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Open-drain bus: either side may pull low.
  assign ps2_clk_pin  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_pin = dev_data & ~ps2_data_oe;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_i  (ps2_clk_pin),
    .ps2_data_i (ps2_data_pin),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .done       (done),
    .ack_ok     (ack_ok),
    .timeout    (timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame as the device should see it: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic hs(input logic [7:0] b, input bit keep);
    int w = 0;
    while (tx_ready !== 1'b1 && w < 100) begin @(negedge clk); w++; end
    chk("hs_ready_wait", 32'(w < 100), 1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    if (!keep) tx_valid = 1'b0;
    chk("hs_accept", {tx_ready, busy, ps2_clk_oe}, 3'b011);
  endtask

  // Device: waits for request-to-send, then clocks n_edges falling edges,
  // sampling data on each rising edge. Edge 11 is the acknowledge slot.
  task automatic dev_run(input int n_edges, input bit dev_ack,
                         output logic [10:0] bits, output int edge_cyc);
    int w = 0;
    bits = '1;
    edge_cyc = cyc;
    while (!(ps2_clk_pin === 1'b1 && ps2_data_pin === 1'b0) && w < 2000) begin
      @(negedge clk); w++;
    end
    chk("dev_rts_seen", 32'(w < 2000), 1);
    bits[0] = ps2_data_pin;
    for (int k = 1; k <= 10 && k <= n_edges; k++) begin
      repeat (H) @(negedge clk);
      dev_clk  = 1'b0;
      edge_cyc = cyc;
      repeat (H) @(negedge clk);
      dev_clk = 1'b1;
      bits[k] = ps2_data_pin;
    end
    if (n_edges >= 11) begin
      repeat (H) @(negedge clk);
      if (dev_ack) dev_data = 1'b0;
      repeat (H) @(negedge clk);
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      dev_clk = 1'b1;
      repeat (H) @(negedge clk);
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_done(output int dc, output logic a, output logic t,
                           output logic [1:0] oe);
    int w = 0;
    while (done !== 1'b1 && w < 5000) begin @(negedge clk); w++; end
    chk("done_seen", 32'(w < 5000), 1);
    dc = cyc;
    a  = ack_ok;
    t  = timeout;
    oe = {ps2_clk_oe, ps2_data_oe};
  endtask

  // Called at the first inhibit cycle; returns at the cycle after done.
  task automatic run_xfer(input logic [7:0] b, input int n_edges, input bit dev_ack,
                          input bit exp_ack, input bit exp_to, input string tag);
    logic [10:0] bits, exp_f, mask;
    logic [1:0]  oe;
    logic        got_ack, got_to;
    int          inh, req_cyc, done_cyc, edge_cyc;
    exp_f = frame_of(b);
    inh = 0;
    while (ps2_clk_oe === 1'b1 && inh < 1000) begin inh++; @(negedge clk); end
    chk({tag, "_inhibit_len"}, inh, INH);
    req_cyc = cyc;
    chk({tag, "_rts_lines"}, {ps2_clk_oe, ps2_data_oe}, 2'b01);
    fork
      dev_run(n_edges, dev_ack, bits, edge_cyc);
      wait_done(done_cyc, got_ack, got_to, oe);
    join
    mask = (n_edges >= 10) ? 11'h7FF : 11'((32'd1 << (n_edges + 1)) - 1);
    chk({tag, "_frame"}, bits & mask, exp_f & mask);
    chk({tag, "_ack_ok"}, got_ack, exp_ack);
    chk({tag, "_timeout"}, got_to, exp_to);
    chk({tag, "_lines_at_done"}, oe, 2'b00);
    // Expiry: TMO cycles after entering REQ, or TMO cycles after the data
    // register reacts to the last pin edge (3 cycles after the pin falls).
    if (n_edges == 0)
      chk({tag, "_to_latency_req"}, done_cyc - req_cyc, TMO);
    else if (n_edges < 11)
      chk({tag, "_to_latency_edge"}, done_cyc - edge_cyc, TMO + 3);
    @(negedge clk);
    chk({tag, "_after_done"}, {done, ack_ok, timeout, tx_ready},
        {1'b0, exp_ack, exp_to, 1'b1});
  endtask

  typedef struct {
    logic [7:0] b;
    int         n_edges;
    bit         dev_ack;
    bit         exp_ack;
    bit         exp_to;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [10:0] bits;
    logic [7:0]  rb;
    int          ec, n, w;
    bit          a;

    tbl[0] = '{8'hED, 11, 1'b1, 1'b1, 1'b0};  // LED command, acked
    tbl[1] = '{8'h3C, 11, 1'b0, 1'b0, 1'b0};  // NACK in ack slot
    tbl[2] = '{8'h00,  0, 1'b1, 1'b0, 1'b1};  // device never clocks
    tbl[3] = '{8'hA5,  5, 1'b1, 1'b0, 1'b1};  // stops after edge 5
    tbl[4] = '{8'hF0, 10, 1'b1, 1'b0, 1'b1};  // no ack edge
    tbl[5] = '{8'h7E, 11, 1'b1, 1'b1, 1'b0};

    clrn = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    dev_clk = 1'b1; dev_data = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", {tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, ack_ok, timeout},
        7'b1000000);
    clrn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      hs(tbl[i].b, 1'b0);
      run_xfer(tbl[i].b, tbl[i].n_edges, tbl[i].dev_ack, tbl[i].exp_ack, tbl[i].exp_to,
               $sformatf("vec%0d", i));
    end

    // Back-to-back with tx_valid held: second handshake the cycle after done.
    hs(8'h01, 1'b1);
    tx_data = 8'hFF;
    run_xfer(8'h01, 11, 1'b1, 1'b1, 1'b0, "b2b_first");
    @(negedge clk);
    chk("b2b_second_hs", {tx_ready, ps2_clk_oe}, 2'b01);
    tx_valid = 1'b0;
    run_xfer(8'hFF, 11, 1'b1, 1'b1, 1'b0, "b2b_second");

    for (int r = 0; r < 6; r++) begin
      rb = 8'($urandom);
      n  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 10)) : 11;
      a  = 1'($urandom_range(0, 1));
      hs(rb, 1'b0);
      run_xfer(rb, n, a, (n >= 11) && a, n < 11, $sformatf("rnd%0d", r));
    end

    // Asynchronous reset while data is pulled low during bit 3.
    hs(8'h00, 1'b0);
    w = 0;
    while (ps2_clk_oe === 1'b1 && w < 100) begin @(negedge clk); w++; end
    dev_run(4, 1'b0, bits, ec);
    chk("rst_pre_data_oe", ps2_data_oe, 1);
    #2 clrn = 1'b0;
    #1;
    chk("rst_async_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    chk("rst_async_flags", {tx_ready, busy, done, ack_ok, timeout}, 5'b10000);
    @(negedge clk);
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    hs(8'hAA, 1'b0);
    run_xfer(8'hAA, 11, 1'b1, 1'b1, 1'b0, "aa_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED LED set, 0xFF reset) from the FPGA to the keyboard using the PS/2 inhibit/request-to-send sequence. It drives the open-drain `ps2_clk`/`ps2_data` lines through active-high pull-low enables, shifts out the frame on device-generated clocks and checks the device acknowledge bit. It sits beside the existing PS/2 receive path on the same pins; while `busy` is high the receive path must ignore line activity.

## Interface
- `INHIBIT_CYCLES`, default 5000: cycles `ps2_clk` is held low before request-to-send (100 µs @ 50 MHz); minimum 2.
- `TIMEOUT_CYCLES`, default 750000: watchdog limit in cycles, from request-to-send to the first falling edge and between consecutive falling edges (15 ms @ 50 MHz).
- `clk`  in  1  system clock, rising edge.
- `clrn`  in  1  asynchronous, active-low reset.
- `tx_data`  in  8  command byte; sampled on handshake.
- `tx_valid`  in  1  request to send `tx_data`.
- `tx_ready`  out  1  high only in IDLE; handshake when `tx_valid && tx_ready`.
- `ps2_clk_i`  in  1  PS/2 clock pin level (asynchronous).
- `ps2_data_i`  in  1  PS/2 data pin level (asynchronous).
- `ps2_clk_oe`  out  1  1 = pull `ps2_clk` low; 0 = release.
- `ps2_data_oe`  out  1  1 = pull `ps2_data` low; 0 = release.
- `busy`  out  1  equals `~tx_ready`.
- `done`  out  1  one-cycle pulse when a transfer ends, whether by success, NACK or timeout.
- `ack_ok`  out  1  valid with `done`: 1 = device pulled data low in the ack slot.
- `timeout`  out  1  valid with `done`: 1 = watchdog expired.

## Operation
- `ps2_clk_i` passes through a 3-flop synchronizer. A falling edge is the sync pair reading previous = 1 and current = 0, giving one pulse per edge. `ps2_data_i` uses a 2-flop synchronizer.
- On handshake, latch `tx_data` into a shift register and set `parity = ~^tx_data` (odd parity).
- States:
  - IDLE: both enables 0, `tx_ready` = 1. On handshake go to INHIBIT and clear the counter.
  - INHIBIT: `ps2_clk_oe` = 1, `ps2_data_oe` = 0 for INHIBIT_CYCLES cycles. Then go to REQ and reload the watchdog.
  - REQ: `ps2_clk_oe` = 0, `ps2_data_oe` = 1 (start bit). Bit index = 0.
  - XFER: on each falling edge, drive the next bit with `ps2_data_oe` = ~bit. Edges 1–8 drive data[0..7] LSB first, edge 9 drives parity, edge 10 drives stop (`ps2_data_oe` = 0). Edge 11 goes to ACK.
  - ACK: on edge 11, sample synchronized data; `ack_ok` = ~data. Go to WAIT_IDLE.
  - WAIT_IDLE: wait until both synchronized lines are 1, then go to DONE. The watchdog still applies.
  - DONE: `done` = 1 for one cycle, then IDLE.
- Watchdog: counts in REQ, XFER, ACK and WAIT_IDLE, and reloads on every falling edge. On reaching TIMEOUT_CYCLES it releases both lines, sets `timeout` = 1 and `ack_ok` = 0, and goes to DONE.
- `tx_valid` outside IDLE is ignored; no queueing.
- Falling edges seen in IDLE or INHIBIT are ignored.

## Timing
- Reset (`clrn` = 0, asynchronous): state IDLE, `ps2_clk_oe` = `ps2_data_oe` = 0, `done` = `ack_ok` = `timeout` = 0, `tx_ready` = 1, counters 0. Reset mid-transfer releases both lines immediately, with no clock edge needed.
- All outputs are registered.
- `tx_ready` falls the cycle after the handshake. `ps2_clk_oe` rises that same cycle.
- `ps2_clk_oe` stays high exactly INHIBIT_CYCLES cycles. `ps2_data_oe` rises and `ps2_clk_oe` falls on the same edge.
- Data changes 3 clk cycles after the pin's falling edge (2 for synchronization, 1 for the register). This is well inside the PS/2 half-period.
- `ack_ok` and `timeout` hold their value from DONE until the next handshake.
- `done` asserts the cycle after both lines are seen high. A new handshake is accepted the cycle after `done`.
- Falling edge and watchdog expiry in the same cycle: the edge wins and the watchdog reloads.

## Test plan
Benches run with INHIBIT_CYCLES = 8 and TIMEOUT_CYCLES = 200.
- Send 0xED with a device model ACKing -> clk held low 8 cycles; bits sampled on device rising edges are start 0, then 1,0,1,1,0,1,1,1, parity 1, stop 1; `done` pulse with `ack_ok` = 1, `timeout` = 0.
- Send 0x01 then 0xFF back-to-back (`tx_valid` held) -> parity 0 then 1; second handshake exactly one cycle after the first `done`; both `ack_ok` = 1.
- Device never clocks after REQ -> at cycle 200 of REQ, lines released, `done` pulses with `timeout` = 1, `ack_ok` = 0.
- Device stops clocking after edge 5 -> timeout 200 cycles after edge 5; `ps2_data_oe` = 0 the same cycle as `done`.
- Device leaves data high in the ack slot -> `done` with `ack_ok` = 0, `timeout` = 0.
- Assert `clrn` = 0 during bit 3 with `ps2_data_oe` = 1 -> `ps2_data_oe` and `ps2_clk_oe` go to 0 combinationally via async reset; after release, `tx_ready` = 1 and 0xAA sends correctly.
